muldiv_unit: RTL

Parametrised multi-cycle multiply/divide unit implementing the full RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at a configurable datapath width. It sits in the execute stage beside the single-cycle ALU. The control unit issues an operation with a one-cycle start pulse, holds the pipeline while the unit is busy, and writes back the registered result on the done pulse. Divide-by-zero and signed-overflow results follow the RISC-V specification and complete on the early-out path.

---
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply, restoring divide, early-out on div special cases.
// Optional MULDIV_FAST_MUL_EN: multiply codes use a single-cycle product and skip the MUL state.
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int MD_CTRL_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Start,
  input  logic [MD_CTRL_WIDTH-1:0] MDControl,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     Busy,
  output logic                     Done,
  output logic [DATA_WIDTH-1:0]    MDResult
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [MD_CTRL_WIDTH-1:0] OP_MUL    = MD_CTRL_WIDTH'(0);
  localparam logic [MD_CTRL_WIDTH-1:0] OP_MULH   = MD_CTRL_WIDTH'(1);
  localparam logic [MD_CTRL_WIDTH-1:0] OP_MULHSU = MD_CTRL_WIDTH'(2);
  localparam logic [MD_CTRL_WIDTH-1:0] OP_MULHU  = MD_CTRL_WIDTH'(3);
  localparam logic [MD_CTRL_WIDTH-1:0] OP_DIV    = MD_CTRL_WIDTH'(4);
  localparam logic [MD_CTRL_WIDTH-1:0] OP_DIVU   = MD_CTRL_WIDTH'(5);
  localparam logic [MD_CTRL_WIDTH-1:0] OP_REM    = MD_CTRL_WIDTH'(6);
  localparam logic [MD_CTRL_WIDTH-1:0] OP_REMU   = MD_CTRL_WIDTH'(7);
  localparam logic [W-1:0]             MIN_NEG   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, next_state;

  logic [MD_CTRL_WIDTH-1:0] ctrl_q;
  logic [CW-1:0]            cnt;
  logic [2*W-1:0]           acc;
  logic [W:0]               rem;
  logic [W-1:0]             quo, mcand, a_orig;
  logic                     neg_p, neg_q, neg_r, div_zero, div_ovf;

  logic            sign_a, sign_b, neg_a, neg_b, is_div, zero_in, ovf_in, early_out;
  logic [W-1:0]    mag_a, mag_b;
  logic [W:0]      mul_sum, div_shift, div_trial;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    rem_fix, result_sel;

  // Operand decode at issue time
  always_comb begin
    sign_a    = (MDControl == OP_MUL) || (MDControl == OP_MULH) || (MDControl == OP_MULHSU) ||
                (MDControl == OP_DIV) || (MDControl == OP_REM);
    sign_b    = (MDControl == OP_MUL) || (MDControl == OP_MULH) ||
                (MDControl == OP_DIV) || (MDControl == OP_REM);
    neg_a     = sign_a & SrcA[W-1];
    neg_b     = sign_b & SrcB[W-1];
    mag_a     = neg_a ? (~SrcA + 1'b1) : SrcA;
    mag_b     = neg_b ? (~SrcB + 1'b1) : SrcB;
    is_div    = MDControl[MD_CTRL_WIDTH-1];
    zero_in   = (SrcB == '0);
    ovf_in    = sign_b && (SrcA == MIN_NEG) && (SrcB == '1);
    early_out = is_div && (zero_in || ovf_in);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (Start) begin
        if (is_div) next_state = early_out ? DONE : DIV;
`ifdef MULDIV_FAST_MUL_EN
        else        next_state = DONE;
`else
        else        next_state = MUL;
`endif
      end
      MUL:     if (cnt == '0) next_state = DONE;
      DIV:     if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // One iteration step of each datapath
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    div_shift = {rem[W-1:0], quo[W-1]};
    div_trial = div_shift - {1'b0, mcand};
  end

  always_comb begin
    prod_fix   = neg_p ? (~acc + 1'b1) : acc;
    rem_fix    = W'(neg_r ? (~rem + 1'b1) : rem);
    result_sel = '0;
    case (ctrl_q)
      OP_MUL:                        result_sel = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result_sel = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:
        if (div_zero)     result_sel = '1;
        else if (div_ovf) result_sel = MIN_NEG;
        else              result_sel = neg_q ? (~quo + 1'b1) : quo;
      OP_REM, OP_REMU:
        if (div_zero)     result_sel = a_orig;
        else if (div_ovf) result_sel = '0;
        else              result_sel = rem_fix;
      default:            result_sel = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ctrl_q   <= '0;
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
      mcand    <= '0;
      a_orig   <= '0;
      neg_p    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      Done     <= 1'b0;
      MDResult <= '0;
    end else begin
      state <= next_state;
      Done  <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          ctrl_q   <= MDControl;
          a_orig   <= SrcA;
          neg_p    <= neg_a ^ neg_b;
          neg_q    <= neg_a ^ neg_b;
          neg_r    <= neg_a;
          div_zero <= is_div && zero_in;
          div_ovf  <= is_div && ovf_in;
          cnt      <= CW'(W-1);
          mcand    <= is_div ? mag_b : mag_a;
          quo      <= mag_a;
          rem      <= '0;
`ifdef MULDIV_FAST_MUL_EN
          acc      <= {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
`else
          acc      <= {{W{1'b0}}, mag_b};
`endif
        end
        MUL: begin
          acc <= {mul_sum, acc[W-1:1]};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DIV: begin
          if (div_trial[W]) begin
            rem <= div_shift;
            quo <= {quo[W-2:0], 1'b0};
          end else begin
            rem <= div_trial;
            quo <= {quo[W-2:0], 1'b1};
          end
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DONE: begin
          MDResult <= result_sel;
          Done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != IDLE);

endmodule
